// File: rtl/lut_wvf_sequencer.sv
// Sequencer for the LUT waveform generator: paced triggers, sample capture, rep/abort status.
// Optional per-repetition watchdog enabled by defining LUT_SEQ_TIMEOUT_EN.
module lut_wvf_sequencer #(
    parameter int BITWIDTH_IN = 16,
    parameter int ADR_WIDTH   = 21,
    parameter int CNT_WIDTH   = 16,
    parameter int REP_WIDTH   = 8
) (
    input  logic                   CLK_SYS,
    input  logic                   nRST,
    input  logic                   EN,
    input  logic                   START,
    input  logic                   STOP,
    input  logic [CNT_WIDTH-1:0]   PRESCALE_IN,
    input  logic [REP_WIDTH-1:0]   REPEAT_IN,
    output logic                   DUT_EN,
    output logic                   DUT_TRGG,
    input  logic [BITWIDTH_IN-1:0] DUT_VALUE,
    input  logic                   DUT_END,
    output logic [BITWIDTH_IN-1:0] DATA_OUT,
    output logic                   DATA_VALID,
    output logic [ADR_WIDTH-1:0]   SAMPLE_CNT,
    output logic [REP_WIDTH-1:0]   REP_CNT,
    output logic                   BUSY,
    output logic                   DONE,
    output logic                   ABORTED,
    output logic                   ERR
);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t               state;
    logic [CNT_WIDTH-1:0] p_reg;
    logic [CNT_WIDTH-1:0] presc;
    logic [REP_WIDTH-1:0] r_reg;
    logic [ADR_WIDTH-1:0] per_rep;
    logic                 cap_pend;
    logic                 trg_raw;
    logic                 last_rep;
    logic                 timeout_hit;

    assign trg_raw  = (state == RUN) && (presc == p_reg);
    // Final END is seen on the capture cycle; a trigger issued then would fetch a stray sample.
    assign last_rep = cap_pend && DUT_END && (r_reg != '0) &&
                      (REP_WIDTH'(REP_CNT + 1'b1) == r_reg);

`ifdef LUT_SEQ_TIMEOUT_EN
    assign timeout_hit = cap_pend && !DUT_END && (ADR_WIDTH'(per_rep + 1'b1) == '1);
`else
    assign timeout_hit = 1'b0;
`endif

    assign DUT_EN   = EN;
    assign DUT_TRGG = trg_raw && EN && !STOP && !last_rep && !timeout_hit;

    always_ff @(posedge CLK_SYS) begin
        if (!nRST) begin
            state      <= IDLE;
            p_reg      <= '0;
            presc      <= '0;
            r_reg      <= '0;
            per_rep    <= '0;
            cap_pend   <= 1'b0;
            DATA_OUT   <= '0;
            DATA_VALID <= 1'b0;
            SAMPLE_CNT <= '0;
            REP_CNT    <= '0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            ABORTED    <= 1'b0;
            ERR        <= 1'b0;
        end else begin
            DATA_VALID <= 1'b0;
            DONE       <= 1'b0;
            cap_pend   <= 1'b0;
            case (state)
                IDLE: begin
                    if (START && EN && !STOP) begin
                        p_reg      <= PRESCALE_IN;
                        r_reg      <= REPEAT_IN;
                        presc      <= '0;
                        per_rep    <= '0;
                        SAMPLE_CNT <= '0;
                        REP_CNT    <= '0;
                        ABORTED    <= 1'b0;
                        ERR        <= 1'b0;
                        BUSY       <= 1'b1;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    if (!EN) begin
                        // Pending capture is dropped; no DONE on an enable loss.
                        ABORTED <= 1'b1;
                        BUSY    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        cap_pend <= DUT_TRGG;
                        presc    <= (presc == p_reg) ? '0 : presc + 1'b1;
                        if (cap_pend) begin
                            DATA_OUT   <= DUT_VALUE;
                            DATA_VALID <= 1'b1;
                            if (SAMPLE_CNT != '1)
                                SAMPLE_CNT <= SAMPLE_CNT + 1'b1;
                            if (DUT_END) begin
                                REP_CNT <= REP_CNT + 1'b1;
                                per_rep <= '0;
                            end else begin
                                per_rep <= per_rep + 1'b1;
                            end
                        end
                        if (STOP || last_rep || timeout_hit) begin
                            DONE  <= 1'b1;
                            state <= FIN;
                        end
                        if (STOP || timeout_hit)
                            ABORTED <= 1'b1;
                        if (timeout_hit)
                            ERR <= 1'b1;
                    end
                end
                FIN: begin
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
